// File: rtl/sim_run_pkg.sv
// sim_run_pkg: shared definitions for the simulation run controller.
//   - run_state_e : 3-bit FSM state encoding (HOLD, RUN and four sticky terminal states)
//   - Prio*       : verdict priority order, lowest value wins when several hold at once
//   - FailChW     : width of the fail_ch index (fixed, covers up to MaxCh cores)
//   - lowest_set  : index of the lowest set bit of a channel vector
package sim_run_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StHold    = 3'd0,
        StRun     = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StHang    = 3'd4,
        StTimeout = 3'd5
    } run_state_e;

    // Verdict priority when several conditions hold in the same RUN cycle.
    localparam int unsigned PrioFail    = 0;
    localparam int unsigned PrioPass    = 1;
    localparam int unsigned PrioHang    = 2;
    localparam int unsigned PrioTimeout = 3;

    localparam int unsigned MaxCh   = 8;
    localparam int unsigned FailChW = 3;

    // Returns the lowest set index, 0 for an empty vector.
    function automatic logic [FailChW-1:0] lowest_set(input logic [MaxCh-1:0] vec);
        logic [FailChW-1:0] idx;
        idx = '0;
        for (int i = MaxCh - 1; i >= 0; i--) begin
            if (vec[i]) idx = FailChW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sim_stall_watch.sv
// sim_stall_watch: per-core progress monitor.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   retire     : core retired an instruction this cycle
//   done       : core signalled end of test this cycle
//   pass       : core verdict, meaningful only with done
//   run_en     : controller is in RUN; inputs are ignored otherwise
//   clear      : synchronous clear of counter and latches (controller in HOLD)
//   done_all   : channel is done (latched earlier or this cycle)
//   pass_all   : channel verdict is pass (latched earlier or this cycle)
//   fail_now   : channel reports done with fail this cycle
//   hang       : stall limit reached this cycle on a channel that is not done
module sim_stall_watch
    import sim_run_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic retire,
    input  logic done,
    input  logic pass,
    input  logic run_en,
    input  logic clear,
    output logic done_all,
    output logic pass_all,
    output logic fail_now,
    output logic hang
);

    localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

    logic [StallW-1:0] stall_q;
    logic              done_q;
    logic              pass_q;
    logic              active;

    assign active = run_en && !done_q;

    always_comb begin
        // done in the same cycle as the stall limit counts as done, not hang
        hang     = active && !done && !retire && (stall_q == StallW'(STALL_LIMIT - 1));
        fail_now = active && done && !pass;
        done_all = done_q || (run_en && done);
        pass_all = done_q ? pass_q : (run_en && done && pass);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (clear) begin
            stall_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (active) begin
            if (done) begin
                done_q <= 1'b1;
                pass_q <= pass;
            end
            if (retire) begin
                stall_q <= '0;
            end else if (stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller for rv32i simulation benches.
// Sequences core reset, counts RUN cycles and ends the run with a sticky verdict.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   retire_i   : per-core instruction-retired strobe
//   done_i     : per-core end-of-test strobe
//   pass_i     : per-core verdict, sampled with done_i
//   core_rst   : reset to all cores (high in HOLD and in terminal states)
//   cycle_cnt  : RUN cycles elapsed, saturating, frozen once the run ends
//   finished   : run over
//   pass/fail/hang/timeout : verdict, exactly one high when finished
//   fail_ch    : lowest core index that failed or hung
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int unsigned N_CH        = 1,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned STALL_LIMIT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    retire_i,
    input  logic [N_CH-1:0]    done_i,
    input  logic [N_CH-1:0]    pass_i,
    output logic               core_rst,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               finished,
    output logic               pass,
    output logic               fail,
    output logic               hang,
    output logic               timeout,
    output logic [FailChW-1:0] fail_ch
);

    localparam int unsigned HoldW = $clog2(RST_CYCLES + 1);

    run_state_e       state_q;
    logic [HoldW-1:0] hold_q;

    logic             run_en;
    logic             clear;
    logic [N_CH-1:0]  done_vec;
    logic [N_CH-1:0]  ok_vec;
    logic [N_CH-1:0]  fail_vec;
    logic [N_CH-1:0]  hang_vec;
    logic [MaxCh-1:0] fail_pad;
    logic [MaxCh-1:0] hang_pad;
    logic             fail_any;
    logic             pass_all;
    logic             hang_any;
    logic             at_budget;

    assign run_en = (state_q == StRun);
    assign clear  = (state_q == StHold);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        sim_stall_watch #(
            .STALL_LIMIT(STALL_LIMIT)
        ) u_watch (
            .clk     (clk),
            .rst     (rst),
            .retire  (retire_i[c]),
            .done    (done_i[c]),
            .pass    (pass_i[c]),
            .run_en  (run_en),
            .clear   (clear),
            .done_all(done_vec[c]),
            .pass_all(ok_vec[c]),
            .fail_now(fail_vec[c]),
            .hang    (hang_vec[c])
        );
    end

    always_comb begin
        fail_pad             = '0;
        hang_pad             = '0;
        fail_pad[N_CH-1:0]   = fail_vec;
        hang_pad[N_CH-1:0]   = hang_vec;
        fail_any             = |fail_vec;
        pass_all             = (&done_vec) && (&ok_vec);
        hang_any             = |hang_vec;
        at_budget            = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
    end

    // Verdict order: fail, pass, hang, timeout. The deciding cycle does not advance cycle_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StHold;
            hold_q    <= '0;
            core_rst  <= 1'b1;
            cycle_cnt <= '0;
            finished  <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            hang      <= 1'b0;
            timeout   <= 1'b0;
            fail_ch   <= '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (hold_q == HoldW'(RST_CYCLES - 1)) begin
                        state_q  <= StRun;
                        core_rst <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                StRun: begin
                    if (fail_any) begin
                        state_q  <= StFail;
                        fail     <= 1'b1;
                        finished <= 1'b1;
                        core_rst <= 1'b1;
                        fail_ch  <= lowest_set(fail_pad);
                    end else if (pass_all) begin
                        state_q  <= StPass;
                        pass     <= 1'b1;
                        finished <= 1'b1;
                        core_rst <= 1'b1;
                    end else if (hang_any) begin
                        state_q  <= StHang;
                        hang     <= 1'b1;
                        finished <= 1'b1;
                        core_rst <= 1'b1;
                        fail_ch  <= lowest_set(hang_pad);
                    end else if (at_budget) begin
                        state_q  <= StTimeout;
                        timeout  <= 1'b1;
                        finished <= 1'b1;
                        core_rst <= 1'b1;
                    end else if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                default: begin
                    // terminal states hold until rst
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed self-checking bench for sim_run_ctrl
// (N_CH=2, RST_CYCLES=4, MAX_CYCLES=1000, STALL_LIMIT=16).
module tb_sim_run_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  retire_i;
    logic [1:0]  done_i;
    logic [1:0]  pass_i;
    logic        core_rst;
    logic [31:0] cycle_cnt;
    logic        finished;
    logic        pass;
    logic        fail;
    logic        hang;
    logic        timeout;
    logic [2:0]  fail_ch;

    int n_cmp = 0;
    int n_err = 0;

    sim_run_ctrl #(
        .N_CH       (2),
        .RST_CYCLES (4),
        .MAX_CYCLES (1000),
        .STALL_LIMIT(16),
        .CNT_W      (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .retire_i (retire_i),
        .done_i   (done_i),
        .pass_i   (pass_i),
        .core_rst (core_rst),
        .cycle_cnt(cycle_cnt),
        .finished (finished),
        .pass     (pass),
        .fail     (fail),
        .hang     (hang),
        .timeout  (timeout),
        .fail_ch  (fail_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Verdict bundle {finished, pass, fail, hang, timeout}.
    function automatic logic [31:0] verdict();
        return 32'({finished, pass, fail, hang, timeout});
    endfunction

    // Reset, release, and step through the hold phase to the first RUN cycle.
    task automatic start_run();
        rst      = 1'b1;
        retire_i = 2'b00;
        done_i   = 2'b00;
        pass_i   = 2'b00;
        tick(1);
        rst = 1'b0;
        tick(4);
    endtask

    initial begin
        rst      = 1'b1;
        retire_i = 2'b00;
        done_i   = 2'b00;
        pass_i   = 2'b00;

        // Reset state
        tick(2);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_verdict", verdict(), 32'd0);
        chk("rst_fail_ch", 32'(fail_ch), 32'd0);

        // Hold sequence: core_rst high for 4 edges after release, low after the 4th
        rst = 1'b0;
        retire_i = 2'b11;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk("hold_core_rst", 32'(core_rst), 32'd1);
        end
        tick(1);
        chk("run_core_rst", 32'(core_rst), 32'd0);
        chk("run_first_cnt", cycle_cnt, 32'd0);

        // PASS: ch0 done at cycle 50, ch1 done at cycle 80
        start_run();
        retire_i = 2'b11;
        tick(50);
        chk("pass_cnt50", cycle_cnt, 32'd50);
        done_i = 2'b01;
        pass_i = 2'b01;
        tick(1);
        done_i = 2'b00;
        pass_i = 2'b00;
        chk("pass_half_verdict", verdict(), 32'd0);
        tick(29);
        chk("pass_cnt80", cycle_cnt, 32'd80);
        done_i = 2'b10;
        pass_i = 2'b10;
        tick(1);
        done_i = 2'b00;
        pass_i = 2'b00;
        chk("pass_verdict", verdict(), 32'b11000);
        chk("pass_cnt", cycle_cnt, 32'd80);
        chk("pass_core_rst", 32'(core_rst), 32'd1);
        tick(5);
        chk("pass_sticky", verdict(), 32'b11000);
        chk("pass_cnt_frozen", cycle_cnt, 32'd80);

        // FAIL: ch1 done with fail at cycle 30, ch0 still running
        start_run();
        retire_i = 2'b11;
        tick(30);
        done_i = 2'b10;
        pass_i = 2'b00;
        tick(1);
        done_i = 2'b00;
        chk("fail_verdict", verdict(), 32'b10100);
        chk("fail_ch1", 32'(fail_ch), 32'd1);
        chk("fail_cnt", cycle_cnt, 32'd30);
        chk("fail_core_rst", 32'(core_rst), 32'd1);

        // Simultaneous done with mixed verdicts gives FAIL
        start_run();
        retire_i = 2'b11;
        tick(5);
        done_i = 2'b11;
        pass_i = 2'b01;
        tick(1);
        done_i = 2'b00;
        pass_i = 2'b00;
        chk("mixed_verdict", verdict(), 32'b10100);
        chk("mixed_fail_ch", 32'(fail_ch), 32'd1);

        // HANG: ch1 never retires
        start_run();
        retire_i = 2'b01;
        tick(15);
        chk("hang_pre", verdict(), 32'd0);
        tick(1);
        chk("hang_verdict", verdict(), 32'b10010);
        chk("hang_fail_ch", 32'(fail_ch), 32'd1);
        chk("hang_cnt", cycle_cnt, 32'd15);

        // Done on the stall-limit cycle counts as done, then ch0 passes
        start_run();
        retire_i = 2'b01;
        tick(15);
        done_i = 2'b10;
        pass_i = 2'b10;
        tick(1);
        done_i = 2'b00;
        pass_i = 2'b00;
        chk("done_at_limit_verdict", verdict(), 32'd0);
        chk("done_at_limit_cnt", cycle_cnt, 32'd16);
        done_i = 2'b01;
        pass_i = 2'b01;
        tick(1);
        done_i = 2'b00;
        pass_i = 2'b00;
        chk("done_at_limit_pass", verdict(), 32'b11000);

        // TIMEOUT at cycle_cnt = 999, then frozen
        start_run();
        retire_i = 2'b11;
        tick(999);
        chk("to_pre_cnt", cycle_cnt, 32'd999);
        chk("to_pre_verdict", verdict(), 32'd0);
        tick(1);
        chk("to_verdict", verdict(), 32'b10001);
        chk("to_cnt", cycle_cnt, 32'd999);
        tick(3);
        chk("to_cnt_frozen", cycle_cnt, 32'd999);

        // Last pass on the budget cycle wins over timeout
        start_run();
        retire_i = 2'b11;
        tick(999);
        done_i = 2'b11;
        pass_i = 2'b11;
        tick(1);
        done_i = 2'b00;
        pass_i = 2'b00;
        chk("pass_at_budget", verdict(), 32'b11000);
        chk("pass_at_budget_cnt", cycle_cnt, 32'd999);

        // Asynchronous rst mid-run clears at once and the hold sequence repeats
        start_run();
        retire_i = 2'b11;
        tick(200);
        chk("mid_cnt200", cycle_cnt, 32'd200);
        rst = 1'b1;
        #1;
        chk("mid_rst_core_rst", 32'(core_rst), 32'd1);
        chk("mid_rst_cnt", cycle_cnt, 32'd0);
        chk("mid_rst_verdict", verdict(), 32'd0);
        tick(1);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk("mid_hold_core_rst", 32'(core_rst), 32'd1);
        end
        tick(1);
        chk("mid_run_core_rst", 32'(core_rst), 32'd0);
        chk("mid_run_cnt", cycle_cnt, 32'd0);
        tick(3);
        chk("mid_run_cnt3", cycle_cnt, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
